// File: rtl/card_shoe_pkg.sv
// Shared card types, deck constants and shoe state encoding for the card shoe.
package cardPkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_SHUFFLE,
    S_READY
  } shoe_state_t;

  // Card sitting at position idx of an unshuffled deck: suit-major, ace first.
  function automatic card_t fresh_card(input logic [5:0] idx);
    card_t c;
    c.suit = 2'(idx / 6'(RANKS));
    c.rank = 4'(idx % 6'(RANKS)) + 4'd1;
    return c;
  endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); exposes the low six bits as a draw sample.
module shoe_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [5:0] o_sample
);

  // An all-zero state would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] START = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] TAPS  = 16'hB400;

  logic [15:0] state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= START;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
    end
  end

  assign o_sample = state[5:0];

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: fills the deck, Fisher-Yates shuffles it from an LFSR, then deals one card per draw cycle.
module card_shoe
  import cardPkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned LOW_THRESHOLD = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_draw,
  input  logic       i_shuffle,
  output logic [5:0] o_card,
  output logic       o_cardValid,
  output logic       o_ready,
  output logic [5:0] o_remaining,
  output logic       o_low,
  output logic       o_empty
);

  localparam logic [5:0] FULL   = 6'(DECK_SIZE);
  localparam logic [5:0] LAST   = 6'(DECK_SIZE - 1);
  localparam logic [5:0] LOW_TH = 6'(LOW_THRESHOLD);

  shoe_state_t state;
  logic [5:0]  idx;   // fill position in S_INIT, shuffle position i in S_SHUFFLE
  logic [5:0]  ptr;
  logic [5:0]  j;
  logic        accept;
  card_t       deck [DECK_SIZE];

  shoe_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_sample(j)
  );

  assign accept = (j <= idx);

  // Deck storage: always a permutation once filled, so a reshuffle never needs a refill.
  always_ff @(posedge i_clk) begin
    case (state)
      S_INIT: deck[idx] <= fresh_card(idx);
      S_SHUFFLE: begin
        if (accept) begin
          deck[idx] <= deck[j];
          deck[j]   <= deck[idx];
        end
      end
      default: ;
    endcase
  end

  // Shoe FSM, counters and registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_INIT;
      idx         <= 6'd0;
      ptr         <= FULL;
      o_card      <= 6'd0;
      o_cardValid <= 1'b0;
      o_ready     <= 1'b0;
      o_remaining <= 6'd0;
      o_low       <= 1'b1;
      o_empty     <= 1'b0;
    end else begin
      o_cardValid <= 1'b0;
      case (state)
        S_INIT: begin
          if (idx == LAST) begin
            state <= S_SHUFFLE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_SHUFFLE: begin
          if (accept) begin
            if (idx == 6'd1) begin
              state       <= S_READY;
              ptr         <= 6'd0;
              o_ready     <= 1'b1;
              o_remaining <= FULL;
              o_low       <= (FULL < LOW_TH);
              o_empty     <= 1'b0;
            end else begin
              idx <= idx - 6'd1;
            end
          end
        end
        S_READY: begin
          if (i_shuffle) begin
            state       <= S_SHUFFLE;
            idx         <= LAST;
            o_ready     <= 1'b0;
            o_remaining <= 6'd0;
            o_low       <= (6'd0 < LOW_TH);
            o_empty     <= 1'b0;
          end else if (i_draw && (ptr < FULL)) begin
            o_card      <= deck[ptr];
            o_cardValid <= 1'b1;
            ptr         <= ptr + 6'd1;
            o_remaining <= o_remaining - 6'd1;
            o_low       <= ((o_remaining - 6'd1) < LOW_TH);
            o_empty     <= (o_remaining == 6'd1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
